// File: rtl/pipeline_skid_register_if.sv
// Handshake bundle between an upstream producer, the skid register and a downstream consumer.
interface pipeline_skid_register_if #(
  parameter int DATA_W = 101,
  parameter int CTRL_W = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );

  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );
endinterface

// File: rtl/pipeline_skid_register.sv
// Two-entry skid register between pipeline stages; in_ready depends only on registered state,
// plus a saturating counter of back-pressured cycles.
module pipeline_skid_register #(
  parameter int DATA_W = 101,
  parameter int CTRL_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      stat_clr,
  output logic [1:0]                occupancy,
  output logic [CNT_W-1:0]          stall_cnt,
  pipeline_skid_register_if.slave   bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic              in_fire, out_fire;
  logic              load_main, load_skid, move_skid;

  assign bus.in_ready  = (state != FULL);
  assign bus.out_valid = (state != EMPTY);
  assign bus.out_data  = main_data;
  // A bubble must never present a live control word (e.g. RegWrite).
  assign bus.out_ctrl  = bus.out_valid ? main_ctrl : '0;

  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;

  always_comb begin
    state_nxt = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            load_main = 1'b1;
            state_nxt = BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            load_main = 1'b1;
          end else if (in_fire) begin
            load_skid = 1'b1;
            state_nxt = FULL;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            move_skid = 1'b1;
            state_nxt = BUSY;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    occupancy = 2'd0;
    case (state)
      EMPTY:   occupancy = 2'd0;
      BUSY:    occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      state <= state_nxt;
      if (load_main) begin
        main_data <= bus.in_data;
        main_ctrl <= bus.in_ctrl;
      end else if (move_skid) begin
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
      end
      if (load_skid) begin
        skid_data <= bus.in_data;
        skid_ctrl <= bus.in_ctrl;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stat_clr) begin
      stall_cnt <= '0;
    end else if (bus.out_valid && !bus.out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_skid_register.sv
// Directed bench for pipeline_skid_register: a queue-based reference checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_pipeline_skid_register;
  localparam int DW = 101;
  localparam int CW = 3;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          stat_clr = 1'b0;
  logic [1:0]    occupancy;
  logic [NW-1:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  pipeline_skid_register_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();

  pipeline_skid_register #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .stat_clr  (stat_clr),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } entry_t;

  entry_t m_q[$];
  int     m_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a FIFO of at most two entries, flushed by flush or reset.
  always @(negedge rst_n) begin
    m_q.delete();
    m_cnt = 0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_q.delete();
      m_cnt = 0;
    end else begin
      bit ofire, ifire;
      ofire = (m_q.size() > 0) && bus.out_ready;
      ifire = bus.in_valid && (m_q.size() < 2);
      if (stat_clr) m_cnt = 0;
      else if ((m_q.size() > 0) && !bus.out_ready && (m_cnt < (1 << NW) - 1)) m_cnt++;
      if (flush) begin
        m_q.delete();
      end else begin
        if (ofire) void'(m_q.pop_front());
        if (ifire) m_q.push_back('{d: bus.in_data, c: bus.in_ctrl});
      end
    end
  end

  always @(negedge clk) begin
    chk("occupancy", 128'(occupancy), 128'(m_q.size()));
    chk("in_ready", 128'(bus.in_ready), 128'(m_q.size() < 2));
    chk("out_valid", 128'(bus.out_valid), 128'(m_q.size() > 0));
    chk("out_ctrl", 128'(bus.out_ctrl), (m_q.size() > 0) ? 128'(m_q[0].c) : 128'd0);
    if (m_q.size() > 0) chk("out_data", 128'(bus.out_data), 128'(m_q[0].d));
    chk("stall_cnt", 128'(stall_cnt), 128'(m_cnt));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_ctrl  = c;
  endtask

  initial begin
    drive(1'b0, '0, '0);
    bus.out_ready = 1'b0;
    #2;
    chk("rst_occ", 128'(occupancy), 128'd0);
    chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_out_data", 128'(bus.out_data), 128'd0);
    chk("rst_stall", 128'(stall_cnt), 128'd0);
    cyc();
    cyc();
    rst_n = 1'b1;

    // Streaming 1..8, each visible one edge after acceptance.
    bus.out_ready = 1'b1;
    for (int unsigned k = 1; k <= 8; k++) begin
      drive(1'b1, DW'(k), CW'(k));
      cyc();
      chk("stream_data", 128'(bus.out_data), 128'(k));
      chk("stream_occ", 128'(occupancy), 128'd1);
      chk("stream_stall", 128'(stall_cnt), 128'd0);
    end
    drive(1'b0, '0, '0);
    cyc();
    chk("stream_drain", 128'(occupancy), 128'd0);

    // Back-pressure: A, B fill both entries; C is held upstream until room appears.
    bus.out_ready = 1'b0;
    drive(1'b1, DW'('hA), 3'd1);
    cyc();
    drive(1'b1, DW'('hB), 3'd2);
    cyc();
    drive(1'b1, DW'('hC), 3'd3);
    cyc();
    cyc();
    chk("bp_occ", 128'(occupancy), 128'd2);
    chk("bp_in_ready", 128'(bus.in_ready), 128'd0);
    chk("bp_head", 128'(bus.out_data), 128'hA);
    bus.out_ready = 1'b1;
    cyc();
    chk("bp_head_b", 128'(bus.out_data), 128'hB);
    cyc();
    chk("bp_head_c", 128'(bus.out_data), 128'hC);
    drive(1'b0, '0, '0);
    cyc();
    chk("bp_empty", 128'(occupancy), 128'd0);

    // Flush while FULL, with D offered on the flush edge.
    bus.out_ready = 1'b0;
    drive(1'b1, DW'('hE), 3'd5);
    cyc();
    drive(1'b1, DW'('hF), 3'd6);
    cyc();
    flush = 1'b1;
    drive(1'b1, DW'('hD), 3'd7);
    cyc();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    chk("flush_occ", 128'(occupancy), 128'd0);
    chk("flush_valid", 128'(bus.out_valid), 128'd0);
    chk("flush_ctrl", 128'(bus.out_ctrl), 128'd0);
    bus.out_ready = 1'b1;
    repeat (3) cyc();
    chk("flush_no_d", 128'(bus.out_valid), 128'd0);

    // Stall counter saturation at 15 and stat_clr priority.
    stat_clr = 1'b1;
    cyc();
    stat_clr = 1'b0;
    chk("clr_zero", 128'(stall_cnt), 128'd0);
    bus.out_ready = 1'b0;
    drive(1'b1, DW'('h77), 3'd4);
    cyc();
    drive(1'b0, '0, '0);
    repeat (20) cyc();
    chk("sat_15", 128'(stall_cnt), 128'd15);
    stat_clr = 1'b1;
    cyc();
    stat_clr = 1'b0;
    chk("sat_clr", 128'(stall_cnt), 128'd0);
    bus.out_ready = 1'b1;
    cyc();

    // Bubble with live-looking control input.
    drive(1'b0, '0, 3'b111);
    repeat (3) cyc();
    chk("bubble_ctrl", 128'(bus.out_ctrl), 128'd0);

    // Asynchronous reset between edges while FULL.
    bus.out_ready = 1'b0;
    drive(1'b1, DW'('h21), 3'd1);
    cyc();
    drive(1'b1, DW'('h22), 3'd2);
    cyc();
    drive(1'b0, '0, '0);
    chk("pre_rst_occ", 128'(occupancy), 128'd2);
    rst_n = 1'b0;
    #1;
    chk("arst_occ", 128'(occupancy), 128'd0);
    chk("arst_in_ready", 128'(bus.in_ready), 128'd1);
    chk("arst_valid", 128'(bus.out_valid), 128'd0);
    chk("arst_ctrl", 128'(bus.out_ctrl), 128'd0);
    chk("arst_data", 128'(bus.out_data), 128'd0);
    chk("arst_stall", 128'(stall_cnt), 128'd0);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, DW'('h55), 3'd2);
    cyc();
    drive(1'b0, '0, '0);
    chk("rel_data", 128'(bus.out_data), 128'h55);
    chk("rel_occ", 128'(occupancy), 128'd1);
    cyc();
    chk("rel_drain", 128'(occupancy), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_skid_register.md
PIPELINE_SKID_REGISTER -- requirements
Module: pipeline_skid_register

Interface
REQ-001 The block SHALL have parameter DATA_W, default 101, meaning payload width (ALU result 32 + read data 32 + rd 5 + PC+4 32).
REQ-002 The block SHALL have parameter CTRL_W, default 3, meaning control width (RegWrite 1 + ResultSrc 2).
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning stall-counter width.
REQ-004 The block SHALL have the port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have the port flush, input, 1 bit: synchronous discard of all held entries.
REQ-007 The block SHALL have the port in_valid, input, 1 bit: upstream entry present.
REQ-008 The block SHALL have the port in_ready, output, 1 bit: block accepts an entry this cycle.
REQ-009 The block SHALL have the port in_data, input, DATA_W bits: upstream payload.
REQ-010 The block SHALL have the port in_ctrl, input, CTRL_W bits: upstream control.
REQ-011 The block SHALL have the port out_valid, output, 1 bit: downstream entry present.
REQ-012 The block SHALL have the port out_ready, input, 1 bit: downstream accepts.
REQ-013 The block SHALL have the port out_data, output, DATA_W bits: head payload.
REQ-014 The block SHALL have the port out_ctrl, output, CTRL_W bits: head control, forced to 0 when out_valid=0.
REQ-015 The block SHALL have the port occupancy, output, 2 bits: entries held (0..2).
REQ-016 The block SHALL have the port stat_clr, input, 1 bit: synchronous clear of stall_cnt.
REQ-017 The block SHALL have the port stall_cnt, output, CNT_W bits: saturating count of back-pressured cycles.

Function
REQ-018 The block SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-019 The block SHALL hold two entries: main (head, drives out_data/out_ctrl) and skid.
REQ-020 The block SHALL implement states EMPTY (0 entries), BUSY (1 entry), and FULL (2 entries); occupancy SHALL be 0, 1 or 2 to match.
REQ-021 The block SHALL drive in_ready = (state != FULL), taken directly from registered state with no combinational path from out_ready.
REQ-022 The block SHALL drive out_valid = (state != EMPTY).
REQ-023 In EMPTY, in_fire SHALL load main and go to BUSY; otherwise the block SHALL stay in EMPTY.
REQ-024 In BUSY with in_fire & out_fire, main SHALL load in_data/in_ctrl and the block SHALL stay in BUSY.
REQ-025 In BUSY with in_fire only, skid SHALL load the input and the block SHALL go to FULL.
REQ-026 In BUSY with out_fire only, the block SHALL go to EMPTY.
REQ-027 In FULL, out_fire SHALL move skid to main and go to BUSY; with no out_fire the block SHALL stay in FULL.
REQ-028 The block SHALL have a latency of 1 cycle: an entry accepted at edge N is on out_data after edge N when the block was EMPTY, or when it was BUSY and the head left on the same edge.
REQ-029 The block SHALL deliver entries strictly in order, with no loss and no duplication, whenever flush=0.
REQ-030 When flush=1, the next state SHALL be EMPTY regardless of other inputs.
REQ-031 When flush=1, the input offered that cycle SHALL be dropped, and an out_fire in that cycle SHALL still count as consumed by downstream.
REQ-032 When flush=1, main and skid contents SHALL be left unchanged; they are don't-care once EMPTY.
REQ-033 stall_cnt SHALL increment by 1 on each cycle with out_valid=1 and out_ready=0.
REQ-034 stall_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-035 stat_clr=1 SHALL set stall_cnt to 0 next edge and SHALL take priority over the increment.
REQ-036 flush SHALL NOT affect stall_cnt.
REQ-037 out_ctrl SHALL be 0 when out_valid=0, so that a bubble never asserts RegWrite.

Reset
REQ-038 rst_n=0 SHALL immediately, without waiting for a clock edge, force: state EMPTY, occupancy 0, in_ready 1, out_valid 0, out_ctrl 0, out_data 0, stall_cnt 0, main and skid 0.
REQ-039 Reset asserted mid-operation SHALL discard all held entries.
REQ-040 After rst_n is released, the first edge SHALL obey REQ-023.

Verification
REQ-041 The bench SHALL cover streaming: in_valid=1 and out_ready=1 every cycle, in_data=1,2,3,... -> out_data=1,2,3,... one cycle later, occupancy stays 1, stall_cnt stays 0.
REQ-042 The bench SHALL cover back-pressure: out_ready=0 while pushing A then B -> occupancy 2, in_ready=0, C held upstream; out_ready=1 -> A, B, C in order, no loss.
REQ-043 The bench SHALL cover a flush at FULL: flush=1 with in_valid=1 (D) -> next cycle occupancy 0, out_valid 0, out_ctrl 0; D never appears.
REQ-044 The bench SHALL cover stall counter saturation: CNT_W=4, out_ready=0 for 20 cycles with one entry held -> stall_cnt 15; stat_clr pulse -> 0.
REQ-045 The bench SHALL cover async reset mid-stream: rst_n low between edges while occupancy is 2 -> outputs per REQ-038 before the next edge; the release edge accepts new data.
REQ-046 The bench SHALL cover a bubble: EMPTY with in_ctrl=3'b111 and in_valid=0 -> out_ctrl stays 0.
